// File: rtl/ez8_pkg.sv
// Shared types for the ez8 shift/rotate execute path.
package ez8_pkg;

   localparam int EZ8_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_SHL = 3'd0,
      OP_SHR = 3'd1,
      OP_SAR = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4,
      OP_RLC = 3'd5,
      OP_RRC = 3'd6,
      OP_LDC = 3'd7
   } shift_op_t;

endpackage

// File: rtl/shifter.sv
// Combinational logical/arithmetic barrel shifter for the ez8 datapath.
module shifter
   import ez8_pkg::*;
(
   input  logic [EZ8_WIDTH-1:0] data_i,
   input  logic [2:0]           amount_i,
   input  logic                 lr_i,
   input  logic                 arith_i,
   output logic [EZ8_WIDTH-1:0] result_o
);

   always_comb begin
      result_o = data_i << amount_i;
      if (lr_i) begin
         if (arith_i) result_o = $signed(data_i) >>> amount_i;
         else         result_o = data_i >> amount_i;
      end
   end

endmodule

// File: rtl/shift_exec.sv
// Registered shift/rotate execute stage; owns the architectural carry flag
// and a one-entry result slot with valid/ready toward writeback.
module shift_exec
   import ez8_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           in_op,
   input  logic [EZ8_WIDTH-1:0] in_data,
   input  logic [2:0]           in_amount,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EZ8_WIDTH-1:0] out_data,
   output logic                 out_z,
   output logic                 out_n,
   output logic                 out_c,
   output logic                 carry
);

   logic [EZ8_WIDTH-1:0] data_q, data_d, sh_res;
   logic                 valid_q, z_q, n_q, c_q, carry_q, carry_d;
   logic                 sh_lr, sh_arith, accept;
   logic [2:0]           n_inv;
   shift_op_t            op;

   assign op       = shift_op_t'(in_op);
   assign sh_lr    = (op != OP_SHL);
   assign sh_arith = (op == OP_SAR);
   assign n_inv    = 3'd0 - in_amount;

   shifter u_shifter (
      .data_i   (in_data),
      .amount_i (in_amount),
      .lr_i     (sh_lr),
      .arith_i  (sh_arith),
      .result_o (sh_res)
   );

   // flush wins over a same-cycle request, so it also gates acceptance
   assign in_ready = (!valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      data_d  = in_data;
      carry_d = carry_q;
      unique case (op)
         OP_SHL: begin
            data_d = sh_res;
            if (in_amount != 3'd0) carry_d = in_data[n_inv];
         end
         OP_SHR, OP_SAR: begin
            data_d = sh_res;
            if (in_amount != 3'd0) carry_d = in_data[in_amount - 3'd1];
         end
         OP_ROL: begin
            data_d = (in_data << in_amount) | (in_data >> n_inv);
            if (in_amount != 3'd0) carry_d = data_d[0];
         end
         OP_ROR: begin
            data_d = (in_data >> in_amount) | (in_data << n_inv);
            if (in_amount != 3'd0) carry_d = data_d[7];
         end
         OP_RLC: begin
            data_d  = {in_data[6:0], carry_q};
            carry_d = in_data[7];
         end
         OP_RRC: begin
            data_d  = {carry_q, in_data[7:1]};
            carry_d = in_data[0];
         end
         OP_LDC: begin
            data_d  = in_data;
            carry_d = in_amount[0];
         end
         default: begin
            data_d  = in_data;
            carry_d = carry_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         data_q  <= data_d;
         z_q     <= (data_d == '0);
         n_q     <= data_d[EZ8_WIDTH-1];
         c_q     <= carry_d;
         carry_q <= carry_d;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_z     = z_q;
   assign out_n     = n_q;
   assign out_c     = c_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_shift_exec.sv
// Directed vector bench for shift_exec.
module tb_shift_exec;

   logic       clk = 1'b0;
   logic       reset, flush, in_valid, in_ready;
   logic [2:0] in_op, in_amount;
   logic [7:0] in_data, out_data;
   logic       out_valid, out_ready, out_z, out_n, out_c, carry;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] d;
      logic [2:0] a;
      logic [7:0] r;
      logic       z;
      logic       n;
      logic       c;
   } vec_t;

   localparam int NV = 21;
   vec_t v [NV];

   shift_exec dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_amount (in_amount),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_z     (out_z),
      .out_n     (out_n),
      .out_c     (out_c),
      .carry     (carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [7:0] d,
                        input logic [2:0] a);
      in_valid  = 1'b1;
      in_op     = op;
      in_data   = d;
      in_amount = a;
   endtask

   initial begin
      v[0]  = '{3'd0, 8'h81, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1};
      v[1]  = '{3'd2, 8'h90, 3'd3, 8'hF2, 1'b0, 1'b1, 1'b0};
      v[2]  = '{3'd1, 8'h90, 3'd4, 8'h09, 1'b0, 1'b0, 1'b0};
      v[3]  = '{3'd7, 8'h33, 3'd1, 8'h33, 1'b0, 1'b0, 1'b1};
      v[4]  = '{3'd5, 8'h80, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1};
      v[5]  = '{3'd6, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1'b1};
      v[6]  = '{3'd3, 8'h96, 3'd3, 8'hB4, 1'b0, 1'b1, 1'b0};
      v[7]  = '{3'd4, 8'h96, 3'd0, 8'h96, 1'b0, 1'b1, 1'b0};
      v[8]  = '{3'd7, 8'h00, 3'd3, 8'h00, 1'b1, 1'b0, 1'b1};
      v[9]  = '{3'd0, 8'h55, 3'd0, 8'h55, 1'b0, 1'b0, 1'b1};
      v[10] = '{3'd0, 8'h00, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0};
      v[11] = '{3'd1, 8'h81, 3'd1, 8'h40, 1'b0, 1'b0, 1'b1};
      v[12] = '{3'd2, 8'h7F, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1};
      v[13] = '{3'd4, 8'h01, 3'd1, 8'h80, 1'b0, 1'b1, 1'b1};
      v[14] = '{3'd3, 8'h80, 3'd1, 8'h01, 1'b0, 1'b0, 1'b1};
      v[15] = '{3'd7, 8'hA5, 3'd2, 8'hA5, 1'b0, 1'b1, 1'b0};
      v[16] = '{3'd6, 8'h03, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1};
      v[17] = '{3'd5, 8'h00, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0};
      v[18] = '{3'd0, 8'h01, 3'd7, 8'h80, 1'b0, 1'b1, 1'b0};
      v[19] = '{3'd2, 8'h80, 3'd1, 8'hC0, 1'b0, 1'b1, 1'b0};
      v[20] = '{3'd1, 8'hFF, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = 3'd0; in_data = 8'h00; in_amount = 3'd0;
      #1;
      chk("rst valid", {7'd0, out_valid}, 8'h00);
      chk("rst data", out_data, 8'h00);
      chk("rst z", {7'd0, out_z}, 8'h00);
      chk("rst n", {7'd0, out_n}, 8'h00);
      chk("rst c", {7'd0, out_c}, 8'h00);
      chk("rst carry", {7'd0, carry}, 8'h00);
      chk("rst in_ready", {7'd0, in_ready}, 8'h01);
      step();
      step();
      reset = 1'b0;
      step();

      // back-to-back issue, one result per cycle
      for (int i = 0; i < NV; i++) begin
         drive(v[i].op, v[i].d, v[i].a);
         chk($sformatf("v%0d in_ready", i), {7'd0, in_ready}, 8'h01);
         step();
         chk($sformatf("v%0d valid", i), {7'd0, out_valid}, 8'h01);
         chk($sformatf("v%0d data", i), out_data, v[i].r);
         chk($sformatf("v%0d z", i), {7'd0, out_z}, {7'd0, v[i].z});
         chk($sformatf("v%0d n", i), {7'd0, out_n}, {7'd0, v[i].n});
         chk($sformatf("v%0d c", i), {7'd0, out_c}, {7'd0, v[i].c});
         chk($sformatf("v%0d carry", i), {7'd0, carry}, {7'd0, v[i].c});
      end

      // stall: slot holds 0x02 while a ROL waits
      drive(3'd0, 8'h01, 3'd1);
      step();
      chk("pre-stall data", out_data, 8'h02);
      out_ready = 1'b0;
      drive(3'd3, 8'h01, 3'd2);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d in_ready", k), {7'd0, in_ready}, 8'h00);
         step();
         chk($sformatf("stall%0d data", k), out_data, 8'h02);
         chk($sformatf("stall%0d valid", k), {7'd0, out_valid}, 8'h01);
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", {7'd0, in_ready}, 8'h01);
      step();
      chk("release data", out_data, 8'h04);
      chk("release valid", {7'd0, out_valid}, 8'h01);
      chk("release carry", {7'd0, carry}, 8'h00);
      in_valid = 1'b0;
      step();
      chk("drain valid", {7'd0, out_valid}, 8'h00);

      // flush beats a pending RLC request
      out_ready = 1'b0;
      drive(3'd7, 8'h11, 3'd1);
      step();
      chk("flush pre carry", {7'd0, carry}, 8'h01);
      drive(3'd5, 8'h00, 3'd0);
      flush = 1'b1;
      #1;
      chk("flush in_ready", {7'd0, in_ready}, 8'h00);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush valid", {7'd0, out_valid}, 8'h00);
      chk("flush carry", {7'd0, carry}, 8'h01);
      chk("flush data", out_data, 8'h11);

      // async reset in the middle of a stall
      drive(3'd0, 8'hFF, 3'd1);
      step();
      chk("prerst data", out_data, 8'hFE);
      chk("prerst n", {7'd0, out_n}, 8'h01);
      drive(3'd0, 8'h01, 3'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid rst valid", {7'd0, out_valid}, 8'h00);
      chk("mid rst data", out_data, 8'h00);
      chk("mid rst n", {7'd0, out_n}, 8'h00);
      chk("mid rst c", {7'd0, out_c}, 8'h00);
      chk("mid rst carry", {7'd0, carry}, 8'h00);
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_exec.md
# shift_exec

Registered execute stage for the ez8 shift/rotate instructions. It accepts a decoded shift request from issue and drives the combinational `shifter` sub-module for logical and arithmetic shifts. It adds rotates and rotate-through-carry, and owns the architectural carry flag. It registers the result and flags into a one-entry output slot, with a valid/ready handshake toward writeback.

## Interface
Parameters: none (8-bit datapath fixed).
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `flush`  in  1  synchronous; drops a pending output
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_op`  in  3  operation code (see Operation)
- `in_data`  in  8  operand
- `in_amount`  in  3  shift/rotate count, 0–7
- `out_valid`  out  1  result slot full
- `out_ready`  in  1  writeback consumes when `out_valid && out_ready`
- `out_data`  out  8  result
- `out_z`  out  1  result == 0
- `out_n`  out  1  result[7]
- `out_c`  out  1  carry after this op
- `carry`  out  1  live architectural carry register

## Operation
- Op codes: 0 SHL, 1 SHR (logical), 2 SAR (arithmetic), 3 ROL, 4 ROR, 5 RLC, 6 RRC, 7 LDC.
- SHL, SHR and SAR produce their result through `shifter`:
  - SHL: lr=0.
  - SHR: lr=1, arith=0.
  - SAR: lr=1, arith=1.
- Carry-out for shifts with n = in_amount ≠ 0:
  - SHL: in_data[8-n].
  - SHR/SAR: in_data[n-1].
- ROL n: (x<<n)|(x>>(8-n)); carry = result[0]. ROR n: (x>>n)|(x<<(8-n)); carry = result[7].
- RLC: 1-bit rotate left through carry. Result = {x[6:0], C}; new C = x[7]. in_amount is ignored.
- RRC: 1-bit rotate right through carry. Result = {C, x[7:1]}; new C = x[0]. in_amount is ignored.
- LDC: result = in_data; C ← in_amount[0].
- Ops 0–4 with n = 0: result = in_data; carry unchanged.
- Carry register updates on every accepted request, in the same clock edge as out_data is loaded. Back-to-back RLC/RRC therefore chain correctly without a bubble.
- out_z and out_n are always derived from the registered result. out_c equals the carry value written by this op.
- flush clears out_valid. It does not restore carry: carry updates at acceptance are architectural and final.

## Timing
- Reset values: out_valid=0, out_data=0, out_z=0, out_n=0, out_c=0, carry=0. in_ready=1 after reset.
- Latency: 1 cycle. Accept at edge k puts the result on the outputs and raises out_valid after edge k.
- in_ready = !out_valid || out_ready (combinational). Full throughput of one op per cycle when writeback is always ready.
- Stall: if out_valid && !out_ready, outputs and carry hold stable and in_ready=0.
- Simultaneous consume and accept in one cycle: the slot reloads and out_valid stays 1.
- flush with in_valid in the same cycle: flush wins. The request is not accepted, in_ready is forced to 0 that cycle, and carry is unchanged.
- Reset asserted mid-operation: all state returns to reset values immediately, and the pending result is lost.

## Structure
- Shared package `ez8_pkg`:
  - Op enum `shift_op_t` with the encodings above.
  - Width constant `EZ8_WIDTH = 8`.
- One sub-module: the existing combinational `shifter`, instantiated once. Rotates, carry extraction and the output register live in `shift_exec`.
- Carry-out selection and rotate logic go in a single combinational `always` block. Registers go in one `always` block with asynchronous reset.

## Test plan
- Reset, then SHL 0x81 by 1 → out_data=0x02, out_c=1, out_z=0, out_n=0, one cycle after accept.
- SAR 0x90 by 3 → 0xF2, out_c=0, out_n=1. Then SHR 0x90 by 4 → 0x09, out_c=0.
- LDC amount=1, then RLC 0x80, then RRC 0x01:
  - RLC → 0x01, C=1.
  - RRC → 0x80, C=1.
  - All issued back-to-back with out_ready=1, and no bubbles.
- ROL 0x96 by 3 → 0xB4, C=0. ROR 0x96 by 0 → 0x96 with C unchanged. SHL 0x00 by 5 → out_z=1.
- Hold out_ready=0 for 3 cycles with in_valid high:
  - in_ready=0 and outputs frozen for those 3 cycles.
  - Release: the first result drains and the next request is accepted on the same edge.
- flush while out_valid=1 and in_valid=1 (RLC pending) → out_valid=0 next cycle, request not accepted, carry unchanged. Assert reset mid-stall → all outputs 0 asynchronously.
